spi_shift_ml: RTL and testbench

//  Parametrised multi-lane SPI shift engine; successor to single-lane shifter.

---
 rtl/spi_shift_pkg.sv | 35 +++
 rtl/spi_lane_mux.sv | 43 ++++
 rtl/spi_shift_ml.sv | 182 ++++++++++++++++++
 tb/tb_spi_shift_ml.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_shift_pkg.sv
// Shared types and helpers for the multi-lane SPI shift engine.
package spi_shift_pkg;

  typedef enum logic [1:0] {
    LANE_SINGLE = 2'b00,
    LANE_DUAL   = 2'b01,
    LANE_QUAD   = 2'b10
  } lane_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_e;

  localparam int SD_MISO_LANE = 1;
  localparam int SD_MOSI_LANE = 0;

  function automatic logic [2:0] step_of(input logic [1:0] lane_mode);
    case (lane_mode)
      2'b01:   step_of = 3'd2;
      2'b10:   step_of = 3'd4;
      default: step_of = 3'd1;
    endcase
  endfunction

  // The reserved encoding 2'b11 behaves as single-lane.
  function automatic lane_mode_e mode_of(input logic [1:0] lane_mode);
    case (lane_mode)
      2'b01:   mode_of = LANE_DUAL;
      2'b10:   mode_of = LANE_QUAD;
      default: mode_of = LANE_SINGLE;
    endcase
  endfunction

endpackage

// File: rtl/spi_lane_mux.sv
// Combinational 4-lane extract/insert at a signed base bit index; lanes whose
// index falls outside [0, n_bits) or at/after step are inactive.
module spi_lane_mux
  import spi_shift_pkg::*;
#(
  parameter int MAX_CHAR = 128,
  parameter int LEN_BITS = $clog2(MAX_CHAR)
) (
  input  logic [MAX_CHAR-1:0] data,
  input  logic [LEN_BITS+1:0] base,
  input  logic [LEN_BITS:0]   n_bits,
  input  logic [2:0]          step,
  input  logic [3:0]          ins_lanes,
  input  logic                ins_en,
  output logic [3:0]          ext_lanes,
  output logic [MAX_CHAR-1:0] data_ins
);

  localparam int SW = LEN_BITS + 2;

  logic [SW-1:0] idx [4];
  logic [3:0]    hit;

  // base is two's complement: the top bit flags a position before bit 0.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      idx[k] = base + SW'(k);
      hit[k] = (3'(k) < step) && !idx[k][SW-1] && (idx[k][LEN_BITS:0] < n_bits);
    end
  end

  always_comb begin
    ext_lanes = '0;
    data_ins  = data;
    for (int k = 0; k < 4; k++) begin
      if (hit[k]) begin
        ext_lanes[k] = data[idx[k][LEN_BITS-1:0]];
        if (ins_en) data_ins[idx[k][LEN_BITS-1:0]] = ins_lanes[k];
      end
    end
  end

endmodule

// File: rtl/spi_shift_ml.sv
// Multi-lane (single/dual/quad) SPI shift engine with abort and done pulse.
// Optional build macro SPI_SHIFT_LOOPBACK_EN adds a loopback input (rx samples sd_out).
module spi_shift_ml
  import spi_shift_pkg::*;
#(
  parameter int MAX_CHAR = 128,
  parameter int LEN_BITS = $clog2(MAX_CHAR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  latch,
  input  logic [MAX_CHAR/8-1:0] byte_sel,
  input  logic [MAX_CHAR-1:0]   p_in,
  input  logic [LEN_BITS-1:0]   len,
  input  logic                  lsb,
  input  logic [1:0]            lane_mode,
  input  logic                  dir_rx,
  input  logic                  go,
  input  logic                  abort,
  input  logic                  pos_edge,
  input  logic                  neg_edge,
  input  logic                  tx_negedge,
  input  logic                  rx_negedge,
  input  logic [3:0]            sd_in,
`ifdef SPI_SHIFT_LOOPBACK_EN
  input  logic                  loopback,
`endif
  output logic [3:0]            sd_out,
  output logic [3:0]            sd_oe,
  output logic                  tip,
  output logic                  last,
  output logic                  done,
  output logic [MAX_CHAR-1:0]   p_out
);

  localparam int CW = LEN_BITS + 1;
  localparam int SW = LEN_BITS + 2;
  localparam int NB = MAX_CHAR / 8;

  shift_state_e        state, state_nxt;
  logic                done_nxt;
  logic [MAX_CHAR-1:0] tx_reg;
  logic [CW-1:0]       tx_cnt, rx_cnt, tx_cnt_nxt, rx_cnt_nxt, tx_dec, rx_dec;
  logic [CW-1:0]       n_live, cfg_n, eff_n, eff_tx_cnt;
  logic                cfg_lsb, cfg_dir_rx, eff_lsb;
  lane_mode_e          cfg_mode, eff_mode;
  logic [2:0]          cfg_step, eff_step;
  logic [SW-1:0]       tx_base, rx_base;
  logic [3:0]          tx_lanes, rx_src, rx_lanes, rx_ext_unused;
  logic [MAX_CHAR-1:0] rx_data, tx_ins_unused;
  logic                tx_edge, rx_edge, rx_store, lb_on;

  assign tip    = (state == ST_SHIFT);
  assign last   = (tx_cnt == '0);
  assign n_live = (len == '0) ? CW'(MAX_CHAR) : CW'(len) + CW'(1);

  // Idle uses the live configuration so sd_out prefetches the first bits.
  assign eff_lsb    = tip ? cfg_lsb : lsb;
  assign eff_mode   = tip ? cfg_mode : mode_of(lane_mode);
  assign eff_n      = tip ? cfg_n : n_live;
  assign eff_tx_cnt = tip ? tx_cnt : n_live;
  assign eff_step   = step_of(eff_mode);
  assign cfg_step   = step_of(cfg_mode);

  assign tx_base = eff_lsb ? (SW'(eff_n) - SW'(eff_tx_cnt)) : (SW'(eff_tx_cnt) - SW'(eff_step));
  assign rx_base = cfg_lsb ? (SW'(cfg_n) - SW'(rx_cnt)) : (SW'(rx_cnt) - SW'(cfg_step));

  spi_lane_mux #(.MAX_CHAR(MAX_CHAR), .LEN_BITS(LEN_BITS)) u_tx_mux (
    .data      (tx_reg),
    .base      (tx_base),
    .n_bits    (eff_n),
    .step      (eff_step),
    .ins_lanes (4'b0000),
    .ins_en    (1'b0),
    .ext_lanes (tx_lanes),
    .data_ins  (tx_ins_unused)
  );

  spi_lane_mux #(.MAX_CHAR(MAX_CHAR), .LEN_BITS(LEN_BITS)) u_rx_mux (
    .data      (p_out),
    .base      (rx_base),
    .n_bits    (cfg_n),
    .step      (cfg_step),
    .ins_lanes (rx_lanes),
    .ins_en    (1'b1),
    .ext_lanes (rx_ext_unused),
    .data_ins  (rx_data)
  );

  always_comb begin
    sd_out = tx_lanes;
    if (eff_mode == LANE_SINGLE) sd_out = 4'(tx_lanes[0]) << SD_MOSI_LANE;
  end

`ifdef SPI_SHIFT_LOOPBACK_EN
  assign lb_on  = loopback;
  assign rx_src = loopback ? sd_out : sd_in;
`else
  assign lb_on  = 1'b0;
  assign rx_src = sd_in;
`endif

  assign rx_lanes = (cfg_mode == LANE_SINGLE) ? {3'b000, rx_src[SD_MISO_LANE]} : rx_src;

  always_comb begin
    sd_oe = '0;
    if (tip && !lb_on) begin
      case (cfg_mode)
        LANE_DUAL: if (!cfg_dir_rx) sd_oe = 4'b0011;
        LANE_QUAD: if (!cfg_dir_rx) sd_oe = 4'b1111;
        default:   sd_oe = 4'b0001;
      endcase
    end
  end

  assign tx_edge  = tx_negedge ? neg_edge : pos_edge;
  assign rx_edge  = rx_negedge ? neg_edge : pos_edge;
  assign tx_dec   = (tx_cnt < CW'(cfg_step)) ? tx_cnt : CW'(cfg_step);
  assign rx_dec   = (rx_cnt < CW'(cfg_step)) ? rx_cnt : CW'(cfg_step);
  assign tx_cnt_nxt = (tx_edge && tx_cnt != '0) ? tx_cnt - tx_dec : tx_cnt;
  assign rx_cnt_nxt = (rx_edge && rx_cnt != '0) ? rx_cnt - rx_dec : rx_cnt;
  assign rx_store = tip && rx_edge && (rx_cnt != '0) && (cfg_mode == LANE_SINGLE || cfg_dir_rx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  // Completion looks at the post-edge counter values so the last shift ends the transfer.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (go) state_nxt = ST_SHIFT;
        ST_SHIFT: if (pos_edge && tx_cnt_nxt == '0 && rx_cnt_nxt == '0) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_reg     <= '0;
      p_out      <= '0;
      tx_cnt     <= '0;
      rx_cnt     <= '0;
      cfg_n      <= '0;
      cfg_lsb    <= 1'b0;
      cfg_dir_rx <= 1'b0;
      cfg_mode   <= LANE_SINGLE;
    end else if (abort || !tip) begin
      tx_cnt <= n_live;
      rx_cnt <= n_live;
      if (!abort && latch) begin
        for (int b = 0; b < NB; b++)
          if (byte_sel[b]) tx_reg[8*b +: 8] <= p_in[8*b +: 8];
      end
      if (!abort && go) begin
        cfg_n      <= n_live;
        cfg_lsb    <= lsb;
        cfg_dir_rx <= dir_rx;
        cfg_mode   <= mode_of(lane_mode);
      end
    end else begin
      tx_cnt <= tx_cnt_nxt;
      rx_cnt <= rx_cnt_nxt;
      if (rx_store) p_out <= rx_data;
    end
  end

endmodule

// File: tb/tb_spi_shift_ml.sv
// Directed self-checking bench for spi_shift_ml (default build, no loopback port).
module tb_spi_shift_ml;

  logic         clk = 1'b0;
  logic         rst;
  logic         latch, lsb, dir_rx, go, abort, pos_edge, neg_edge, tx_negedge, rx_negedge;
  logic [15:0]  byte_sel;
  logic [127:0] p_in;
  logic [6:0]   len;
  logic [1:0]   lane_mode;
  logic [3:0]   sd_drv;
  logic         loop_en;
  logic [3:0]   sd_in_w, sd_out, sd_oe;
  logic         tip, last, done;
  logic [127:0] p_out;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  assign sd_in_w = loop_en ? {2'b00, sd_out[0], 1'b0} : sd_drv;

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  spi_shift_ml dut (
    .clk(clk), .rst(rst), .latch(latch), .byte_sel(byte_sel), .p_in(p_in), .len(len),
    .lsb(lsb), .lane_mode(lane_mode), .dir_rx(dir_rx), .go(go), .abort(abort),
    .pos_edge(pos_edge), .neg_edge(neg_edge), .tx_negedge(tx_negedge), .rx_negedge(rx_negedge),
    .sd_in(sd_in_w), .sd_out(sd_out), .sd_oe(sd_oe), .tip(tip), .last(last), .done(done),
    .p_out(p_out)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic strobe_pos();
    pos_edge = 1'b1;
    @(negedge clk);
    pos_edge = 1'b0;
  endtask

  task automatic strobe_neg();
    neg_edge = 1'b1;
    @(negedge clk);
    neg_edge = 1'b0;
  endtask

  task automatic start(input logic [127:0] data, input logic do_latch, input logic [6:0] l,
                       input logic lsb_i, input logic [1:0] mode, input logic dir);
    p_in = data; latch = do_latch; byte_sel = '1; len = l; lsb = lsb_i;
    lane_mode = mode; dir_rx = dir; go = 1'b1;
    @(negedge clk);
    latch = 1'b0; go = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (tip !== 1'b0) begin errors++; $display("FAIL reset_tip got=%b exp=0", tip); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (sd_out !== 4'h0) begin errors++; $display("FAIL reset_sd_out got=%h exp=0", sd_out); end
    checks++; if (sd_oe !== 4'h0) begin errors++; $display("FAIL reset_sd_oe got=%h exp=0", sd_oe); end
    checks++; if (p_out !== 128'h0) begin errors++; $display("FAIL reset_p_out got=%h exp=0", p_out); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_msb();
    logic [7:0] w;
    int d0;
    w = 8'hA5; d0 = done_cnt;
    loop_en = 1'b1; tx_negedge = 1'b1; rx_negedge = 1'b0;
    start(128'hA5, 1'b1, 7'd7, 1'b0, 2'b00, 1'b0);
    checks++; if (tip !== 1'b1) begin errors++; $display("FAIL single_tip_rise got=%b exp=1", tip); end
    checks++; if (sd_oe !== 4'b0001) begin errors++; $display("FAIL single_sd_oe got=%h exp=1", sd_oe); end
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL single_last_start got=%b exp=0", last); end
    for (int i = 7; i >= 0; i--) begin
      checks++;
      if (sd_out[0] !== w[i]) begin errors++; $display("FAIL single_bit%0d got=%b exp=%b", i, sd_out[0], w[i]); end
      strobe_pos();
      strobe_neg();
    end
    checks++; if (last !== 1'b1) begin errors++; $display("FAIL single_last_end got=%b exp=1", last); end
    checks++; if (tip !== 1'b1) begin errors++; $display("FAIL single_tip_hold got=%b exp=1", tip); end
    strobe_pos();
    checks++; if (tip !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL single_complete tip=%b done=%b exp tip=0 done=1", tip, done); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got=%b exp=0", done); end
    checks++; if (p_out !== 128'hA5) begin errors++; $display("FAIL single_p_out got=%h exp=a5", p_out); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_quad_lsb();
    logic [31:0] w;
    w = 32'h12345678;
    loop_en = 1'b0; sd_drv = 4'h0; tx_negedge = 1'b0; rx_negedge = 1'b0;
    start(128'h12345678, 1'b1, 7'd31, 1'b1, 2'b10, 1'b0);
    checks++; if (sd_oe !== 4'hF) begin errors++; $display("FAIL quad_sd_oe got=%h exp=f", sd_oe); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sd_out !== w[4*i +: 4]) begin errors++; $display("FAIL quad_nibble%0d got=%h exp=%h", i, sd_out, w[4*i +: 4]); end
      strobe_pos();
      if (i == 6) begin
        checks++; if (tip !== 1'b1) begin errors++; $display("FAIL quad_tip_7 got=%b exp=1", tip); end
      end
    end
    checks++; if (tip !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL quad_complete tip=%b done=%b exp tip=0 done=1", tip, done); end
    checks++; if (p_out !== 128'hA5) begin errors++; $display("FAIL quad_p_out_kept got=%h exp=a5", p_out); end
    tick();
  endtask

  task automatic test_dual_short();
    start(128'h15, 1'b1, 7'd4, 1'b0, 2'b01, 1'b0);
    checks++; if (sd_oe !== 4'b0011) begin errors++; $display("FAIL dual_sd_oe got=%h exp=3", sd_oe); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sd_out !== 4'b0010) begin errors++; $display("FAIL dual_shift%0d got=%b exp=0010", i, sd_out); end
      strobe_pos();
      if (i == 1) begin
        checks++; if (tip !== 1'b1) begin errors++; $display("FAIL dual_tip_2 got=%b exp=1", tip); end
      end
    end
    checks++; if (tip !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL dual_complete tip=%b done=%b exp tip=0 done=1", tip, done); end
    tick();
  endtask

  task automatic test_quad_rx();
    logic [15:0] nib;
    nib = 16'hABCD;
    start(128'h0, 1'b0, 7'd15, 1'b0, 2'b10, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      sd_drv = nib[4*i +: 4];
      checks++;
      if (sd_oe !== 4'h0) begin errors++; $display("FAIL quadrx_sd_oe%0d got=%h exp=0", i, sd_oe); end
      strobe_pos();
    end
    checks++; if (tip !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL quadrx_complete tip=%b done=%b exp tip=0 done=1", tip, done); end
    checks++; if (p_out !== 128'hABCD) begin errors++; $display("FAIL quadrx_p_out got=%h exp=abcd", p_out); end
    sd_drv = 4'h0;
    tick();
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_cnt;
    loop_en = 1'b1; tx_negedge = 1'b1; rx_negedge = 1'b0;
    start(128'h3C, 1'b1, 7'd7, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      strobe_pos();
      strobe_neg();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (tip !== 1'b0) begin errors++; $display("FAIL abort_tip got=%b exp=0", tip); end
    checks++; if (sd_oe !== 4'h0) begin errors++; $display("FAIL abort_sd_oe got=%h exp=0", sd_oe); end
    checks++; if (p_out !== 128'hAB2D) begin errors++; $display("FAIL abort_partial got=%h exp=ab2d", p_out); end
    tick();
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_no_done got=%0d exp=%0d", done_cnt, d0); end
    start(128'h0, 1'b0, 7'd7, 1'b0, 2'b00, 1'b0);
    checks++; if (sd_out[0] !== 1'b0 || tip !== 1'b1) begin errors++; $display("FAIL abort_restart sd0=%b tip=%b exp 0 1", sd_out[0], tip); end
    for (int i = 0; i < 8; i++) begin
      strobe_pos();
      strobe_neg();
    end
    strobe_pos();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_rerun_done got=%b exp=1", done); end
    tick();
    checks++; if (p_out !== 128'hAB3C) begin errors++; $display("FAIL abort_rerun_p_out got=%h exp=ab3c", p_out); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL abort_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_latch_in_tip();
    start(128'hFF, 1'b1, 7'd7, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        p_in = 128'h0; latch = 1'b1;
        tick();
        latch = 1'b0;
      end
      strobe_pos();
      strobe_neg();
    end
    strobe_pos();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL latch_done got=%b exp=1", done); end
    tick();
    checks++; if (p_out !== 128'hABFF) begin errors++; $display("FAIL latch_p_out got=%h exp=abff", p_out); end
    checks++; if (sd_out[0] !== 1'b1) begin errors++; $display("FAIL latch_reg_kept got=%b exp=1", sd_out[0]); end
  endtask

  task automatic test_reset_mid();
    start(128'h0, 1'b0, 7'd7, 1'b0, 2'b00, 1'b0);
    strobe_pos();
    strobe_neg();
    strobe_pos();
    strobe_neg();
    checks++; if (sd_out[0] !== 1'b1 || tip !== 1'b1) begin errors++; $display("FAIL rstmid_pre sd0=%b tip=%b exp 1 1", sd_out[0], tip); end
    #2 rst = 1'b1;
    #1;
    checks++; if (tip !== 1'b0 || sd_oe !== 4'h0) begin errors++; $display("FAIL rstmid_ctrl tip=%b sd_oe=%h exp 0 0", tip, sd_oe); end
    checks++; if (sd_out !== 4'h0 || p_out !== 128'h0) begin errors++; $display("FAIL rstmid_data sd_out=%h p_out=%h exp 0 0", sd_out, p_out); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; latch = 1'b0; byte_sel = '0; p_in = '0; len = '0; lsb = 1'b0;
    lane_mode = 2'b00; dir_rx = 1'b0; go = 1'b0; abort = 1'b0; pos_edge = 1'b0;
    neg_edge = 1'b0; tx_negedge = 1'b0; rx_negedge = 1'b0; sd_drv = 4'h0; loop_en = 1'b0;
    tick();
    test_reset();
    test_single_msb();
    test_quad_lsb();
    test_dual_short();
    test_quad_rx();
    test_abort();
    test_latch_in_tip();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
